// File: rtl/timer_host_sequencer_pkg.sv
// timer_host_pkg: op codes, timer register map and control bits shared by the sequencer and its bench
package timer_host_pkg;
  localparam logic [2:0] OP_PROGRAM  = 3'd1;
  localparam logic [2:0] OP_START    = 3'd2;
  localparam logic [2:0] OP_STOP     = 3'd3;
  localparam logic [2:0] OP_SNAPSHOT = 3'd4;
  localparam logic [2:0] OP_STATUS   = 3'd5;
  localparam logic [3:0] ADDR_STATUS  = 4'd0;
  localparam logic [3:0] ADDR_CONTROL = 4'd1;
  localparam logic [3:0] ADDR_PERIOD0 = 4'd2;
  localparam logic [3:0] ADDR_PERIOD1 = 4'd3;
  localparam logic [3:0] ADDR_PERIOD2 = 4'd4;
  localparam logic [3:0] ADDR_PERIOD3 = 4'd5;
  localparam logic [3:0] ADDR_SNAP0   = 4'd6;
  localparam logic [3:0] ADDR_SNAP1   = 4'd7;
  localparam logic [3:0] ADDR_SNAP2   = 4'd8;
  localparam logic [3:0] ADDR_SNAP3   = 4'd9;
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;
  typedef enum logic [2:0] {S_IDLE, S_IRQ_CLR, S_WRITE, S_RD_ADDR, S_RD_WAIT, S_RESP} state_e;
  function automatic logic [15:0] ctrl_word(input logic stop, input logic [1:0] ctrl);
    logic [15:0] w;
    w = '0;
    w[stop ? CTRL_STOP : CTRL_START] = 1'b1;
    w[CTRL_CONT] = ctrl[1];
    w[CTRL_ITO] = ctrl[0];
    return w;
  endfunction
endpackage

// File: rtl/timer_host_sequencer_if.sv
// timer_host_sequencer_if: command/response, Avalon-MM and IRQ/timeout signals of the timer sequencer
interface timer_host_sequencer_if #(parameter int COUNT_W = 16);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_op;
  logic [63:0]        cmd_period;
  logic [1:0]         cmd_ctrl;
  logic               rsp_valid;
  logic [63:0]        rsp_data;
  logic               rsp_err;
  logic [3:0]         avm_address;
  logic               avm_chipselect;
  logic               avm_write_n;
  logic               avm_read;
  logic [15:0]        avm_writedata;
  logic [15:0]        avm_readdata;
  logic               avm_waitrequest;
  logic               timer_irq;
  logic               timeout_pulse;
  logic [COUNT_W-1:0] timeout_count;
  modport master (
    input  cmd_valid, cmd_op, cmd_period, cmd_ctrl, avm_readdata, avm_waitrequest, timer_irq,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, avm_address, avm_chipselect, avm_write_n,
           avm_read, avm_writedata, timeout_pulse, timeout_count
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_period, cmd_ctrl, avm_readdata, avm_waitrequest, timer_irq,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, avm_address, avm_chipselect, avm_write_n,
           avm_read, avm_writedata, timeout_pulse, timeout_count
  );
endinterface

// File: rtl/timer_host_sequencer.sv
// timer_host_sequencer: Avalon-MM master sequencing the interval-timer register map and servicing its IRQ
module timer_host_sequencer
  import timer_host_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int COUNT_W      = 16,
  parameter bit AUTO_CLEAR   = 1'b1
) (
  input logic clk,
  input logic reset,
  timer_host_sequencer_if.master bus
);
  state_e                  state_q;
  logic [2:0]              op_q;
  logic [47:0]             period_q;
  logic [47:0]             acc_q;
  logic [1:0]              idx_q;
  logic [2:0]              cap_left_q;
  logic [READ_LATENCY-1:0] vpipe_q;
  logic                    accept;
  logic                    capture;
  logic                    last_cap;
  logic [15:0]             rd;
  assign accept = bus.avm_chipselect && !bus.avm_waitrequest;
  assign capture = vpipe_q[READ_LATENCY-1];
  assign last_cap = capture && cap_left_q == 3'd1;
  assign rd = bus.avm_readdata;
  assign bus.cmd_ready = state_q == S_IDLE && !(AUTO_CLEAR && bus.timer_irq);
  // vpipe_q tracks accepted reads so each halfword is captured READ_LATENCY edges after its address
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q <= '0;
      period_q <= '0;
      acc_q <= '0;
      idx_q <= '0;
      cap_left_q <= '0;
      vpipe_q <= '0;
      bus.avm_address <= '0;
      bus.avm_chipselect <= 1'b0;
      bus.avm_write_n <= 1'b1;
      bus.avm_read <= 1'b0;
      bus.avm_writedata <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err <= 1'b0;
      bus.rsp_data <= '0;
      bus.timeout_pulse <= 1'b0;
      bus.timeout_count <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.timeout_pulse <= 1'b0;
      vpipe_q <= (vpipe_q << 1) | READ_LATENCY'(accept && bus.avm_read);
      if (capture) begin
        acc_q <= {rd, acc_q[47:16]};
        cap_left_q <= cap_left_q - 3'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (AUTO_CLEAR && bus.timer_irq) begin
            state_q <= S_IRQ_CLR;
            bus.avm_chipselect <= 1'b1;
            bus.avm_write_n <= 1'b0;
            bus.avm_address <= ADDR_STATUS;
            bus.avm_writedata <= '0;
          end else if (bus.cmd_valid) begin
            op_q <= bus.cmd_op;
            period_q <= bus.cmd_period[63:16];
            idx_q <= '0;
            case (bus.cmd_op)
              OP_PROGRAM, OP_START, OP_STOP, OP_SNAPSHOT: begin
                state_q <= S_WRITE;
                bus.avm_chipselect <= 1'b1;
                bus.avm_write_n <= 1'b0;
                bus.avm_address <= bus.cmd_op == OP_PROGRAM ? ADDR_PERIOD0 :
                                   bus.cmd_op == OP_SNAPSHOT ? ADDR_SNAP0 : ADDR_CONTROL;
                bus.avm_writedata <= bus.cmd_op == OP_PROGRAM ? bus.cmd_period[15:0] :
                                     bus.cmd_op == OP_SNAPSHOT ? 16'h0 :
                                     ctrl_word(bus.cmd_op == OP_STOP, bus.cmd_ctrl);
              end
              OP_STATUS: begin
                state_q <= S_RD_ADDR;
                cap_left_q <= 3'd1;
                bus.avm_chipselect <= 1'b1;
                bus.avm_read <= 1'b1;
                bus.avm_address <= ADDR_STATUS;
              end
              default: begin
                state_q <= S_RESP;
                bus.rsp_valid <= 1'b1;
                bus.rsp_err <= 1'b1;
                bus.rsp_data <= '0;
              end
            endcase
          end
        end
        S_IRQ_CLR: begin
          if (accept) begin
            state_q <= S_IDLE;
            bus.avm_chipselect <= 1'b0;
            bus.avm_write_n <= 1'b1;
            bus.timeout_pulse <= 1'b1;
            bus.timeout_count <= bus.timeout_count + COUNT_W'(1);
          end
        end
        S_WRITE: begin
          if (accept) begin
            if (op_q == OP_PROGRAM && idx_q != 2'd3) begin
              idx_q <= idx_q + 2'd1;
              bus.avm_address <= bus.avm_address + 4'd1;
              bus.avm_writedata <= 16'(period_q >> {idx_q, 4'b0});
            end else if (op_q == OP_SNAPSHOT) begin
              state_q <= S_RD_ADDR;
              idx_q <= '0;
              cap_left_q <= 3'd4;
              bus.avm_write_n <= 1'b1;
              bus.avm_read <= 1'b1;
              bus.avm_address <= ADDR_SNAP0;
              bus.avm_writedata <= '0;
            end else begin
              state_q <= S_RESP;
              bus.avm_chipselect <= 1'b0;
              bus.avm_write_n <= 1'b1;
              bus.avm_address <= '0;
              bus.avm_writedata <= '0;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err <= 1'b0;
              bus.rsp_data <= '0;
            end
          end
        end
        S_RD_ADDR: begin
          if (accept) begin
            if (idx_q == (op_q == OP_SNAPSHOT ? 2'd3 : 2'd0)) begin
              state_q <= S_RD_WAIT;
              bus.avm_chipselect <= 1'b0;
              bus.avm_read <= 1'b0;
              bus.avm_address <= '0;
            end else begin
              idx_q <= idx_q + 2'd1;
              bus.avm_address <= bus.avm_address + 4'd1;
            end
          end
        end
        S_RD_WAIT: begin
          if (last_cap) begin
            state_q <= S_RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err <= 1'b0;
            bus.rsp_data <= op_q == OP_STATUS ? {62'b0, rd[1:0]} : {rd, acc_q};
            if (!AUTO_CLEAR && op_q == OP_STATUS && rd[0]) begin
              bus.timeout_pulse <= 1'b1;
              bus.timeout_count <= bus.timeout_count + COUNT_W'(1);
            end
          end
        end
        S_RESP: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_timer_host_sequencer.sv
// tb_timer_host_sequencer: random commands against a transaction-level model with a timer slave and random stalls
module tb_timer_host_sequencer;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  timer_host_sequencer_if #(.COUNT_W(CW)) bus();
  timer_host_sequencer #(.READ_LATENCY(1), .COUNT_W(CW), .AUTO_CLEAR(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  int n_vec = 0;
  int n_bad = 0;
  logic [63:0] obs_q[$];
  int stall_cnt = 0;
  int pulse_cnt = 0;
  int exp_pulses = 0;
  int irq_raised = 0;
  int irq_cleared = 0;
  int stall_req = 0;
  int stall_done = 0;
  logic [3:0] stall_addr = 4'd0;
  bit rand_stall = 1'b0;
  logic [63:0] snap_val = '0;
  logic [63:0] snap_lat = '0;
  logic [1:0] status_val = '0;
  logic [CW-1:0] exp_to = '0;
  logic [63:0] held;
  bit stalled = 1'b0;
  assign bus.timer_irq = irq_raised != irq_cleared;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] xfer(input bit wr, input logic [3:0] a, input logic [15:0] d);
    return {43'b0, wr, a, wr ? d : 16'h0};
  endfunction
  // timer slave: registered readdata, snapshot latch on addr6 write, IRQ dropped by the status clear
  always @(posedge clk) begin
    if (reset) stalled = 1'b0;
    else begin
      if (stalled)
        check("hold", {42'b0, bus.avm_address, bus.avm_write_n, bus.avm_read, bus.avm_writedata}, held);
      stalled = bus.avm_chipselect && bus.avm_waitrequest;
      held = {42'b0, bus.avm_address, bus.avm_write_n, bus.avm_read, bus.avm_writedata};
      if (stalled) stall_cnt++;
      if (bus.avm_chipselect && !bus.avm_waitrequest) begin
        obs_q.push_back(xfer(!bus.avm_write_n, bus.avm_address, bus.avm_writedata));
        if (!bus.avm_write_n && bus.avm_address == 4'd0) irq_cleared <= irq_raised;
        if (!bus.avm_write_n && bus.avm_address == 4'd6) snap_lat = snap_val;
        if (bus.avm_read)
          bus.avm_readdata <= bus.avm_address == 4'd0 ? {14'($urandom), status_val} :
                              bus.avm_address >= 4'd6 ? 16'(snap_lat >> (16 * (int'(bus.avm_address) - 6))) : 16'h0;
      end
      if (bus.timeout_pulse) pulse_cnt++;
    end
  end
  always @(negedge clk) begin
    if (stall_req != stall_done && bus.avm_chipselect && bus.avm_address == stall_addr) begin
      bus.avm_waitrequest = 1'b1;
      stall_done++;
    end else bus.avm_waitrequest = rand_stall && ($urandom_range(3) == 0);
  end
  task automatic do_cmd(input logic [2:0] op, input logic [63:0] per, input logic [1:0] ctl,
                        input bit irq, input logic [63:0] sv);
    logic [63:0] exp_q[$];
    logic [63:0] exp_data;
    bit exp_err, rdy;
    int base, cyc, st0, tries;
    exp_data = '0;
    exp_err = 1'b0;
    base = 1;
    rdy = 1'b0;
    @(negedge clk);
    obs_q.delete();
    snap_val = sv;
    status_val = 2'($urandom);
    if (irq) begin
      irq_raised++;
      exp_to++;
      exp_pulses++;
      exp_q.push_back(xfer(1'b1, 4'd0, 16'd0));
    end
    case (op)
      3'd1: begin
        for (int i = 0; i < 4; i++) exp_q.push_back(xfer(1'b1, 4'(2 + i), per[16*i +: 16]));
        base = 5;
      end
      3'd2, 3'd3: begin
        exp_q.push_back(xfer(1'b1, 4'd1, {12'b0, (op == 3'd2 ? 4'b0100 : 4'b1000) | {2'b0, ctl}}));
        base = 2;
      end
      3'd4: begin
        exp_q.push_back(xfer(1'b1, 4'd6, 16'd0));
        for (int i = 0; i < 4; i++) exp_q.push_back(xfer(1'b0, 4'(6 + i), 16'd0));
        base = 7;
        exp_data = sv;
      end
      3'd5: begin
        exp_q.push_back(xfer(1'b0, 4'd0, 16'd0));
        base = 3;
        exp_data = {62'b0, status_val};
      end
      default: exp_err = 1'b1;
    endcase
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_period = per;
    bus.cmd_ctrl = ctl;
    tries = 0;
    forever begin
      #1 rdy = bus.cmd_ready;
      if (irq && tries == 0) check("irq_blocks_ready", 64'(rdy), 64'd0);
      @(posedge clk);
      if (rdy || tries > 40) break;
      tries++;
      @(negedge clk);
    end
    if (!rdy) begin
      check("accept_timeout", 64'd0, 64'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    st0 = stall_cnt;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 3'($urandom);
    bus.cmd_period = {$urandom, $urandom};
    bus.cmd_ctrl = 2'($urandom);
    cyc = 1;
    while (!bus.rsp_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check("rsp_seen", 64'(bus.rsp_valid), 64'd1);
    check("latency", 64'(cyc), 64'(base + stall_cnt - st0));
    check("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
    check("rsp_data", bus.rsp_data, exp_data);
    @(negedge clk);
    check("rsp_pulse", 64'(bus.rsp_valid), 64'd0);
    check("ready_back", 64'(bus.cmd_ready), 64'd1);
    check("xfer_count", 64'(obs_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) if (i < obs_q.size()) check("xfer", obs_q[i], exp_q[i]);
    check("to_count", 64'(bus.timeout_count), 64'(exp_to));
    check("to_pulses", 64'(pulse_cnt), 64'(exp_pulses));
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 64'(bus.cmd_ready), 64'd1);
    check({tag, "_bus"}, {42'b0, bus.avm_address, bus.avm_chipselect, bus.avm_write_n, bus.avm_read, bus.avm_writedata},
          {42'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'd0});
    check({tag, "_rsp"}, {bus.rsp_valid, bus.rsp_err, bus.timeout_pulse}, 64'd0);
    check({tag, "_count"}, 64'(bus.timeout_count), 64'd0);
  endtask
  initial begin
    int tries;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_period = '0;
    bus.cmd_ctrl = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_data", bus.rsp_data, 64'd0);
    reset = 1'b0;
    do_cmd(3'd1, 64'h1_86A0, 2'b00, 1'b0, 64'd0);
    do_cmd(3'd2, 64'd0, 2'b11, 1'b0, 64'd0);
    do_cmd(3'd3, 64'd0, 2'b10, 1'b0, 64'd0);
    do_cmd(3'd2, 64'd0, 2'b01, 1'b1, 64'd0);
    do_cmd(3'd4, 64'd0, 2'b00, 1'b0, 64'h0000_0001_0000_1234);
    do_cmd(3'd5, 64'd0, 2'b00, 1'b0, 64'd0);
    stall_addr = 4'd3;
    stall_req += 3;
    do_cmd(3'd1, 64'hDEAD_BEEF_0123_4567, 2'b00, 1'b0, 64'd0);
    @(negedge clk);
    obs_q.delete();
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'd1;
    bus.cmd_period = 64'h1111_2222_3333_4444;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    tries = 0;
    while (obs_q.size() < 2 && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    check("t6_two_writes", 64'(obs_q.size()), 64'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_to = '0;
    check_idle("t6");
    do_cmd(3'd7, 64'd0, 2'b00, 1'b0, 64'd0);
    rand_stall = 1'b1;
    for (int n = 0; n < 60; n++)
      do_cmd(3'($urandom_range(7)), {$urandom, $urandom}, 2'($urandom), $urandom_range(3) == 0,
             {$urandom, $urandom});
    for (int n = 0; n < 18; n++) do_cmd(3'd5, 64'd0, 2'b00, 1'b1, 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
